// File: rtl/grid_adc_sched_if.sv
// Signal bundle for grid_adc_sched: Avalon-MM control slave, request/result
// streams, ADC engine command/response and interrupt.
interface grid_adc_sched_if;
  logic [31:0] avs_ctrl_writedata;
  logic [31:0] avs_ctrl_readdata;
  logic [2:0]  avs_ctrl_address;
  logic [3:0]  avs_ctrl_byteenable;
  logic        avs_ctrl_write;
  logic        avs_ctrl_read;
  logic        avs_ctrl_waitrequest;
  logic        asi_req_valid;
  logic [3:0]  asi_req_ch;
  logic        asi_req_ready;
  logic        cmd_valid;
  logic [3:0]  cmd_ch;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [3:0]  rsp_ch;
  logic [11:0] rsp_data;
  logic        aso_res_valid;
  logic [3:0]  aso_res_ch;
  logic [11:0] aso_res_data;
  logic        irq;

  modport slave (
    input  avs_ctrl_writedata, avs_ctrl_address, avs_ctrl_byteenable,
           avs_ctrl_write, avs_ctrl_read, asi_req_valid, asi_req_ch,
           cmd_ready, rsp_valid, rsp_ch, rsp_data,
    output avs_ctrl_readdata, avs_ctrl_waitrequest, asi_req_ready,
           cmd_valid, cmd_ch, aso_res_valid, aso_res_ch, aso_res_data, irq
  );

  modport master (
    output avs_ctrl_writedata, avs_ctrl_address, avs_ctrl_byteenable,
           avs_ctrl_write, avs_ctrl_read, asi_req_valid, asi_req_ch,
           cmd_ready, rsp_valid, rsp_ch, rsp_data,
    input  avs_ctrl_readdata, avs_ctrl_waitrequest, asi_req_ready,
           cmd_valid, cmd_ch, aso_res_valid, aso_res_ch, aso_res_data, irq
  );
endinterface

// File: rtl/grid_adc_sched.sv
// ADC conversion scheduler: periodic masked channel scans arbitrated
// round-robin against one-shot external requests, with response timeout.
module grid_adc_sched #(
  parameter int unsigned TMO_W = 10
) (
  input  logic            csi_MCLK_clk,
  input  logic            rsi_MRST_reset_n,
  grid_adc_sched_if.slave bus
);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]       state;
  logic             run, irq_en, scan_done, tmo_err;
  logic [15:0]      ch_mask, period, scan_cnt, tmr, period_eff, wr_mask;
  logic [3:0]       last_ch, cur_ch, hit_ch;
  logic [11:0]      last_data;
  logic [4:0]       scan_ptr;
  logic             scan_pend, last_ext, cur_ext;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      rd_mux;
  logic             scan_req, grant_ext, hit_found, tmr_hit, rsp_hit, tmo_hit, busy;
  logic             unused_bits;

  assign unused_bits = ^{bus.avs_ctrl_writedata[31:16], bus.avs_ctrl_byteenable[3:2]};

  always_comb begin
    wr_mask    = {{8{bus.avs_ctrl_byteenable[1]}}, {8{bus.avs_ctrl_byteenable[0]}}};
    period_eff = (period == 16'd0) ? 16'd1 : period;
    tmr_hit    = run && (tmr >= period_eff - 16'd1);
    scan_req   = scan_pend && run;
    grant_ext  = bus.asi_req_valid && (!scan_req || !last_ext);
    rsp_hit    = (state == ST_WAIT) && bus.rsp_valid && (bus.rsp_ch == cur_ch);
    tmo_hit    = (state == ST_WAIT) && !rsp_hit && (&tmo_cnt);
    busy       = (state != ST_IDLE);
    // Lowest enabled channel at or above the scan pointer, from the live mask
    hit_found  = 1'b0;
    hit_ch     = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!hit_found && ch_mask[i] && (5'(i) >= scan_ptr)) begin
        hit_found = 1'b1;
        hit_ch    = 4'(i);
      end
    end
    case (bus.avs_ctrl_address)
      3'd0:    rd_mux = 32'd32;
      3'd1:    rd_mux = 32'hEA68_0010;
      3'd2:    rd_mux = {23'd0, irq_en, 7'd0, run};
      3'd3:    rd_mux = {16'd0, ch_mask};
      3'd4:    rd_mux = {16'd0, period};
      3'd5:    rd_mux = {scan_cnt, 6'd0, tmo_err, scan_done, 7'd0, busy};
      3'd6:    rd_mux = {12'd0, last_ch, 4'd0, last_data};
      default: rd_mux = '0;
    endcase
  end

  assign bus.avs_ctrl_waitrequest = 1'b0;
  assign bus.asi_req_ready        = (state == ST_ARB) && grant_ext;
  assign bus.cmd_valid            = (state == ST_ISSUE);
  assign bus.cmd_ch               = cur_ch;
  assign bus.irq                  = irq_en && (scan_done || tmo_err);

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      bus.avs_ctrl_readdata <= '0;
      run       <= 1'b0;
      irq_en    <= 1'b0;
      ch_mask   <= '0;
      period    <= 16'hFFFF;
      scan_done <= 1'b0;
      tmo_err   <= 1'b0;
      scan_cnt  <= '0;
      last_ch   <= '0;
      last_data <= '0;
    end else begin
      bus.avs_ctrl_readdata <= rd_mux;
      if (bus.avs_ctrl_write) begin
        case (bus.avs_ctrl_address)
          3'd2: begin
            if (bus.avs_ctrl_byteenable[0]) run    <= bus.avs_ctrl_writedata[0];
            if (bus.avs_ctrl_byteenable[1]) irq_en <= bus.avs_ctrl_writedata[8];
          end
          3'd3: ch_mask <= (ch_mask & ~wr_mask) | (bus.avs_ctrl_writedata[15:0] & wr_mask);
          3'd4: period  <= (period & ~wr_mask) | (bus.avs_ctrl_writedata[15:0] & wr_mask);
          3'd5: if (bus.avs_ctrl_byteenable[1]) begin
            if (bus.avs_ctrl_writedata[8]) scan_done <= 1'b0;
            if (bus.avs_ctrl_writedata[9]) tmo_err   <= 1'b0;
          end
          default: ;
        endcase
      end
      // Hardware set events take priority over a same-cycle clear
      if (state == ST_DONE) begin
        scan_done <= 1'b1;
        scan_cnt  <= scan_cnt + 16'd1;
      end
      if (tmo_hit) tmo_err <= 1'b1;
      if (rsp_hit) begin
        last_ch   <= cur_ch;
        last_data <= bus.rsp_data;
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state             <= ST_IDLE;
      tmr               <= '0;
      scan_pend         <= 1'b0;
      scan_ptr          <= '0;
      last_ext          <= 1'b0;
      cur_ext           <= 1'b0;
      cur_ch            <= '0;
      tmo_cnt           <= '0;
      bus.aso_res_valid <= 1'b0;
      bus.aso_res_ch    <= '0;
      bus.aso_res_data  <= '0;
    end else begin
      bus.aso_res_valid <= 1'b0;
      if (!run || tmr_hit) tmr <= '0;
      else                 tmr <= tmr + 16'd1;
      // scan_pend covers the whole scan, so an expiry mid-scan is dropped
      if (tmr_hit && (ch_mask != 16'd0) && !scan_pend) begin
        scan_pend <= 1'b1;
        scan_ptr  <= '0;
      end
      case (state)
        ST_IDLE: begin
          if (scan_pend && !run) scan_pend <= 1'b0;
          if (scan_req || bus.asi_req_valid) state <= ST_ARB;
        end
        ST_ARB: begin
          if (grant_ext) begin
            cur_ext  <= 1'b1;
            last_ext <= 1'b1;
            cur_ch   <= bus.asi_req_ch;
            state    <= ST_ISSUE;
          end else if (scan_req) begin
            cur_ext  <= 1'b0;
            last_ext <= 1'b0;
            if (hit_found) begin
              cur_ch   <= hit_ch;
              scan_ptr <= {1'b0, hit_ch} + 5'd1;
              state    <= ST_ISSUE;
            end else begin
              state <= ST_DONE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (bus.cmd_ready) begin
            tmo_cnt <= '0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rsp_hit) begin
            state <= ST_IDLE;
            if (cur_ext) begin
              bus.aso_res_valid <= 1'b1;
              bus.aso_res_ch    <= cur_ch;
              bus.aso_res_data  <= bus.rsp_data;
            end else if (!run) begin
              scan_pend <= 1'b0;
            end
          end else if (tmo_hit) begin
            state <= ST_IDLE;
            if (!cur_ext) scan_pend <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          scan_pend <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/grid_adc_sched.md
GRID_ADC_SCHED -- requirements
Module: grid_adc_sched

Interface
REQ-001 Parameter TMO_W, default 10: width of the response-timeout counter; timeout is 2**TMO_W clocks.
REQ-002 csi_MCLK_clk  in  1  sole clock; all logic is rising-edge.
REQ-003 rsi_MRST_reset_n  in  1  asynchronous, active-low reset.
REQ-004 avs_ctrl_writedata in 32, avs_ctrl_readdata out 32, avs_ctrl_address in 3, avs_ctrl_byteenable in 4, avs_ctrl_write in 1, avs_ctrl_read in 1: Avalon-MM control slave.
REQ-005 avs_ctrl_waitrequest  out  1  tied 0.
REQ-006 asi_req_valid in 1, asi_req_ch in 4, asi_req_ready out 1: one-shot conversion requests from an external requester.
REQ-007 cmd_valid out 1, cmd_ch out 4, cmd_ready in 1: conversion command to the ADC engine.
REQ-008 rsp_valid in 1, rsp_ch in 4, rsp_data in 12: conversion result from the ADC engine.
REQ-009 aso_res_valid out 1, aso_res_ch out 4, aso_res_data out 12: result returned to the external requester.
REQ-010 irq  out  1  scan-complete or error interrupt.

Function
REQ-011 The register map SHALL be:
- 0 SIZE: reads 32.
- 1 ID: reads 32'hEA68_0010.
- 2 CTRL: bit0 run, bit8 irq_en; RW.
- 3 CH_MASK: bits[15:0]; RW.
- 4 PERIOD: bits[15:0] scan period in clocks; RW.
- 5 STATUS: bit0 busy, bit8 scan_done, bit9 tmo_err, bits[31:16] scan_cnt; writing 1 to bit8/bit9 clears that bit.
- 6 LAST: {ch[19:16], data[11:0]}; RO.
- 7: reads 0.
REQ-012 readdata SHALL be registered: valid 1 clock after address; writes honour byteenable per byte.
REQ-013 The period timer SHALL count up while run=1; on reaching PERIOD it SHALL reset to 0 and set scan_pend if CH_MASK!=0; PERIOD=0 SHALL act as PERIOD=1.
REQ-014 A scan SHALL visit enabled channels in ascending order 0..15, skipping masked channels without spending a clock per skipped channel beyond 1 search clock.
REQ-015 The FSM SHALL use the states IDLE, ARB, ISSUE, WAIT, DONE.
REQ-016 IDLE->ARB when scan_pend or asi_req_valid.
REQ-017 ARB SHALL grant round-robin between scan and external: on contention, the source not granted last wins; with no contention, the sole requester wins.
REQ-018 Granting an external request SHALL pulse asi_req_ready for 1 clock and latch asi_req_ch.
REQ-019 ISSUE SHALL hold cmd_valid=1 and cmd_ch stable until cmd_ready; the cycle with cmd_valid&cmd_ready SHALL move to WAIT.
REQ-020 WAIT SHALL accept a rsp_valid whose rsp_ch equals the issued channel, and SHALL ignore a mismatching rsp_valid.
REQ-021 On an accepted response, LAST SHALL update; for an external grant, aso_res_* SHALL pulse valid for exactly 1 clock on the following clock.
REQ-022 If WAIT lasts 2**TMO_W clocks, the block SHALL set tmo_err, abort the current scan (scan_pend cleared), and return to IDLE.
REQ-023 After the last enabled channel of a scan, DONE SHALL set scan_done, increment scan_cnt (wrapping at 16'hFFFF->0), clear scan_pend, and return to IDLE.
REQ-024 A timer expiry while a scan is in progress SHALL be dropped; scans never queue.
REQ-025 busy SHALL equal (state!=IDLE).
REQ-026 irq SHALL equal irq_en & (scan_done | tmo_err).
REQ-027 Clearing run mid-scan SHALL finish the in-flight conversion, then stop the scan; external requests SHALL still be served.
REQ-028 CH_MASK changes mid-scan SHALL take effect at the next channel search.

Reset
REQ-029 Assertion of rsi_MRST_reset_n SHALL asynchronously force:
- state IDLE;
- all registers to 0, except PERIOD=16'hFFFF;
- cmd_valid, asi_req_ready, aso_res_valid and irq to 0;
- readdata to 0.
REQ-030 Reset mid-handshake SHALL drop the command; after reset deassertion a stale rsp_valid SHALL be ignored.

Verification
REQ-031 Reset, then read addresses 0/1/4 -> 32, 32'hEA680010, 32'h0000FFFF.
REQ-032 CH_MASK=16'h0005, PERIOD=100, run=1, ADC engine responds in 5 clocks -> cmd_ch sequence 0,2; LAST={2,data}; scan_cnt=1; irq=0 until irq_en=1.
REQ-033 Scan pending with asi_req_valid held at ch 7 -> grants alternate scan/external; aso_res_valid pulses once with ch 7.
REQ-034 cmd_ready held 0 for 20 clocks -> cmd_valid and cmd_ch stay stable for all 20 clocks.
REQ-035 No rsp_valid for 1024 clocks (TMO_W=10) -> tmo_err=1, FSM returns to IDLE, write 1 to STATUS bit9 clears tmo_err.
REQ-036 Assert reset during WAIT -> all outputs 0 immediately; a subsequent mismatched rsp_valid does not update LAST.
